// File: rtl/alarm_clock_pkg.sv
// Shared encodings for the alarm clock: set modes, BCD field layout and limits.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  localparam int M1_LSB  = 0;
  localparam int M10_LSB = 4;
  localparam int H1_LSB  = 8;
  localparam int H10_LSB = 12;

  localparam int MIN_ONES_MAX = 9;
  localparam int MIN_TENS_MAX = 5;
  localparam int HOUR_MAX     = 23;
  localparam int HOUR_ONES_MAX = 9;

  localparam logic [15:0] TIME_RESET = 16'h0000;

  // Time-set wins over alarm-set when both switches are on.
  function automatic mode_t decode_mode(input logic change_time, input logic change_alarm);
    if (change_time)       return MODE_SET_TIME;
    else if (change_alarm) return MODE_SET_ALARM;
    else                   return MODE_RUN;
  endfunction

endpackage

// File: rtl/bcd_hhmm_counter.sv
// 24-hour BCD HH:MM register with minute/hour increments; minute wrap feeds hours only when carry_en.
module bcd_hhmm_counter
  import alarm_clock_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_min,
  input  logic        inc_hr,
  input  logic        carry_en,
  output logic [15:0] value
);

  logic [3:0]  m1, m10, h1, h10;
  logic [15:0] nxt;
  logic        min_wrap;
  logic        hr_step;

  assign m1  = value[M1_LSB  +: 4];
  assign m10 = value[M10_LSB +: 4];
  assign h1  = value[H1_LSB  +: 4];
  assign h10 = value[H10_LSB +: 4];

  always_comb begin
    nxt      = value;
    min_wrap = 1'b0;
    if (inc_min) begin
      if (m1 == 4'(MIN_ONES_MAX)) begin
        nxt[M1_LSB +: 4] = 4'd0;
        if (m10 == 4'(MIN_TENS_MAX)) begin
          nxt[M10_LSB +: 4] = 4'd0;
          min_wrap          = 1'b1;
        end else begin
          nxt[M10_LSB +: 4] = m10 + 4'd1;
        end
      end else begin
        nxt[M1_LSB +: 4] = m1 + 4'd1;
      end
    end

    // Hour edits and minute carries never coincide in this block's users, so one step suffices.
    hr_step = inc_hr | (min_wrap & carry_en);
    if (hr_step) begin
      if (h10 == 4'(HOUR_MAX / 10) && h1 == 4'(HOUR_MAX % 10)) begin
        nxt[H10_LSB +: 4] = 4'd0;
        nxt[H1_LSB  +: 4] = 4'd0;
      end else if (h1 == 4'(HOUR_ONES_MAX)) begin
        nxt[H10_LSB +: 4] = h10 + 4'd1;
        nxt[H1_LSB  +: 4] = 4'd0;
      end else begin
        nxt[H1_LSB +: 4] = h1 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= TIME_RESET;
    else        value <= nxt;
  end

endmodule

// File: rtl/clock_time_keeper.sv
// 1 Hz time base, running BCD time of day and alarm setting with button-driven edits.
module clock_time_keeper
  import alarm_clock_pkg::*;
#(
  parameter int CLKS_PER_SEC = 25_000_000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Change_Time,
  input  logic        i_Change_Alarm,
  input  logic        i_Hours_Inc,
  input  logic        i_Minutes_Inc,
  output logic [15:0] o_Time,
  output logic [15:0] o_Alarm_Time,
  output logic        o_Second_Tick,
  output logic [5:0]  o_Seconds
);

  localparam int PW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

  mode_t       mode;
  logic        set_time, set_alarm;
  logic        min_q, min_prev, hr_q, hr_prev;
  logic        min_evt, hr_evt;
  logic [PW-1:0] presc;
  logic        tick_now, sec_wrap;

  assign mode      = decode_mode(i_Change_Time, i_Change_Alarm);
  assign set_time  = (mode == MODE_SET_TIME);
  assign set_alarm = (mode == MODE_SET_ALARM);

  // Edge history resets high so a button held through reset release is not an event.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      min_q    <= 1'b1;
      min_prev <= 1'b1;
      hr_q     <= 1'b1;
      hr_prev  <= 1'b1;
    end else begin
      min_q    <= i_Minutes_Inc;
      min_prev <= min_q;
      hr_q     <= i_Hours_Inc;
      hr_prev  <= hr_q;
    end
  end

  assign min_evt = min_q & ~min_prev;
  assign hr_evt  = hr_q  & ~hr_prev;

  assign tick_now = !set_time && (presc == PRESC_LAST);
  assign sec_wrap = tick_now && (o_Seconds == 6'd59);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc         <= '0;
      o_Seconds     <= 6'd0;
      o_Second_Tick <= 1'b0;
    end else if (set_time) begin
      presc         <= '0;
      o_Seconds     <= 6'd0;
      o_Second_Tick <= 1'b0;
    end else begin
      o_Second_Tick <= tick_now;
      if (tick_now) begin
        presc     <= '0;
        o_Seconds <= sec_wrap ? 6'd0 : o_Seconds + 6'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  bcd_hhmm_counter u_time (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .inc_min  (sec_wrap | (set_time & min_evt)),
    .inc_hr   (set_time & hr_evt),
    .carry_en (~set_time),
    .value    (o_Time)
  );

  bcd_hhmm_counter u_alarm (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .inc_min  (set_alarm & min_evt),
    .inc_hr   (set_alarm & hr_evt),
    .carry_en (1'b0),
    .value    (o_Alarm_Time)
  );

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed bench for clock_time_keeper with CLKS_PER_SEC = 4.
module tb_clock_time_keeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        change_time = 1'b0, change_alarm = 1'b0;
  logic        hours_inc = 1'b0, minutes_inc = 1'b0;
  logic [15:0] time_v, alarm_v;
  logic        tick;
  logic [5:0]  seconds;

  int total = 0, bad = 0;
  int tick_cnt = 0, first_tick = -1, set_ticks = 0;
  bit mon_set = 1'b0;

  clock_time_keeper #(.CLKS_PER_SEC(4)) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Change_Time  (change_time),
    .i_Change_Alarm (change_alarm),
    .i_Hours_Inc    (hours_inc),
    .i_Minutes_Inc  (minutes_inc),
    .o_Time         (time_v),
    .o_Alarm_Time   (alarm_v),
    .o_Second_Tick  (tick),
    .o_Seconds      (seconds)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_set && tick) set_ticks++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic hr, input logic mn);
    hours_inc = hr; minutes_inc = mn;
    repeat (2) @(negedge clk);
    hours_inc = 1'b0; minutes_inc = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_n(input logic hr, input logic mn, input int n);
    for (int i = 0; i < n; i++) press(hr, mn);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_time", time_v, 16'h0000);
    check("rst_alarm", alarm_v, 16'h0000);
    check("rst_sec", {10'd0, seconds}, 16'd0);
    check("rst_tick", {15'd0, tick}, 16'd0);

    // 240 cycles of RUN: 60 ticks, first at cycle 4, one minute elapsed
    rst_n = 1'b1;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (tick) begin
        tick_cnt++;
        if (first_tick < 0) first_tick = i;
      end
    end
    check("tick_count", 16'(tick_cnt), 16'd60);
    check("first_tick", 16'(first_tick), 16'd4);
    check("run_sec", {10'd0, seconds}, 16'd0);
    check("run_time", time_v, 16'h0001);

    // SET_TIME edits and wraps
    change_time = 1'b1;
    @(negedge clk);
    mon_set = 1'b1;
    press_n(1'b1, 1'b0, 23);
    check("set_h23", time_v, 16'h2301);
    press_n(1'b0, 1'b1, 58);
    check("set_2359", time_v, 16'h2359);
    press(1'b0, 1'b1);
    check("min_wrap_nocarry", time_v, 16'h2300);
    press(1'b1, 1'b0);
    check("hr_wrap", time_v, 16'h0000);
    press_n(1'b0, 1'b1, 59);
    check("set_0059", time_v, 16'h0059);
    press(1'b0, 1'b1);
    check("min_wrap_0059", time_v, 16'h0000);
    press_n(1'b1, 1'b0, 23);
    press_n(1'b0, 1'b1, 59);
    check("preload_2359", time_v, 16'h2359);
    check("set_sec_held", {10'd0, seconds}, 16'd0);
    mon_set = 1'b0;
    check("set_no_tick", 16'(set_ticks), 16'd0);

    // RUN one minute from 23:59 -> midnight rollover
    change_time = 1'b0;
    repeat (240) @(negedge clk);
    check("midnight", time_v, 16'h0000);
    check("midnight_sec", {10'd0, seconds}, 16'd0);

    // both switches: time-set priority
    change_time = 1'b1; change_alarm = 1'b1;
    press(1'b1, 1'b0);
    check("prio_time", time_v, 16'h0100);
    check("prio_alarm", alarm_v, 16'h0000);

    // SET_ALARM, both edges in one cycle, with latency check
    change_time = 1'b0;
    hours_inc = 1'b1; minutes_inc = 1'b1;
    @(negedge clk);
    check("alarm_lat_n", alarm_v, 16'h0000);
    @(negedge clk);
    check("alarm_both", alarm_v, 16'h0101);
    hours_inc = 1'b0; minutes_inc = 1'b0;
    repeat (2) @(negedge clk);
    press_n(1'b0, 1'b1, 58);
    check("alarm_0159", alarm_v, 16'h0159);
    press(1'b0, 1'b1);
    check("alarm_min_wrap", alarm_v, 16'h0100);

    // held button across reset release is not an event
    rst_n = 1'b0;
    change_alarm = 1'b0; change_time = 1'b1; minutes_inc = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("held_rst_time", time_v, 16'h0000);
    minutes_inc = 1'b0;
    repeat (2) @(negedge clk);

    // RUN ignores increments
    change_time = 1'b0;
    press_n(1'b1, 1'b1, 5);
    check("run_ign_time", time_v, 16'h0000);
    check("run_ign_alarm", alarm_v, 16'h0000);

    // preload 12:34 and alarm 01:00, then async reset mid-second
    change_time = 1'b1;
    press_n(1'b1, 1'b0, 12);
    press_n(1'b0, 1'b1, 34);
    change_time = 1'b0; change_alarm = 1'b1;
    press(1'b1, 1'b0);
    change_alarm = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_time", time_v, 16'h1234);
    check("pre_alarm", alarm_v, 16'h0100);
    check("pre_sec", {10'd0, seconds}, 16'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_time", time_v, 16'h0000);
    check("async_alarm", alarm_v, 16'h0000);
    check("async_sec", {10'd0, seconds}, 16'd0);
    check("async_tick", {15'd0, tick}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Time-base and settings register block for the alarm clock. Divides the system clock to a 1 Hz tick, keeps the running 24-hour time of day in BCD, and holds the alarm time. Applies user hour/minute increments to either the time or the alarm, depending on the set mode. Sits directly upstream of the master controller: its `o_Time` and `o_Alarm_Time` drive that block's time and alarm-time inputs, and the same button/switch levels feed both blocks.

## Interface
- `CLKS_PER_SEC`, default 25_000_000: system clock cycles per second; must be ≥ 2.
- `i_Clk`  in  1: system clock; all logic on the rising edge.
- `i_Rst_n`  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `i_Change_Time`  in  1: level, selects time-set mode.
- `i_Change_Alarm`  in  1: level, selects alarm-set mode.
- `i_Hours_Inc`  in  1: debounced level; each rising edge is one hour increment.
- `i_Minutes_Inc`  in  1: debounced level; each rising edge is one minute increment.
- `o_Time`  out  16: current time, BCD {H10, H1, M10, M1}, range 00:00–23:59.
- `o_Alarm_Time`  out  16: alarm time, same encoding.
- `o_Second_Tick`  out  1: one-cycle pulse at each seconds increment.
- `o_Seconds`  out  6: binary seconds, 0–59.

## Operation
**Modes** (combinational from levels, evaluated every cycle):
- SET_TIME when `i_Change_Time` = 1. This holds regardless of `i_Change_Alarm`; time-set has priority.
- SET_ALARM when `i_Change_Time` = 0 and `i_Change_Alarm` = 1.
- RUN otherwise.

**Edge detect:**
- Each increment input is registered once.
- An event is `in & ~prev`.
- `prev` registers reset to 1, so a button held through reset release generates no event.

**Prescaler:**
- Counts 0..`CLKS_PER_SEC`-1 and wraps.
- At terminal count, `o_Second_Tick` = 1 for that cycle.
- On each tick, seconds advance by 1.
- Seconds 59→0 carries one minute into the time counter. The carry ripples M1→M10→H1→H10.
- 23:59:59 → 00:00:00.

**SET_TIME:**
- Prescaler and seconds are held at 0. No ticks occur and there is no carry.
- Minute event: M 59→00. Never carries into hours.
- Hour event: H 23→00.

**Leaving SET_TIME:**
- Prescaler restarts from 0. The first tick comes `CLKS_PER_SEC` cycles after the first RUN/SET_ALARM cycle.

**SET_ALARM:**
- Time keeps running normally.
- Minute/hour events modify `o_Alarm_Time` with the same no-carry wrap rules.

**RUN:** increment events are ignored (discarded, not queued).

**Both edges in one cycle:** both increments apply.

**Tick concurrent with an alarm edit (SET_ALARM):** both apply; the registers are independent.

**Mode switch in the same cycle as an edge:** the edge applies to the mode decoded that cycle.

**BCD digit rules:**
- M1 0–9, M10 0–5, H1 0–9 (0–3 when H10 = 2), H10 0–2.
- Illegal codes never appear.

## Timing
- Reset values: `o_Time` = 16'h0000, `o_Alarm_Time` = 16'h0000, `o_Seconds` = 0, `o_Second_Tick` = 0, prescaler = 0.
- Reset is asynchronous assert; release is synchronous to `i_Clk`.
- Reset mid-count discards all state.
- All outputs are registered.
- Increment latency: input first sampled high at edge N → new value visible after edge N+1.
- Tick: `o_Second_Tick` is high in the same cycle that `o_Seconds` and, on carry, `o_Time` show the new value. It is registered together with them.
- From reset release in RUN: first tick at cycle `CLKS_PER_SEC`, and every `CLKS_PER_SEC` cycles thereafter.
- One minute of `o_Time` = 60 × `CLKS_PER_SEC` cycles.

## Structure
- Shared package `alarm_clock_pkg`:
  - mode encoding (RUN, SET_TIME, SET_ALARM);
  - BCD field positions and limits (MIN_ONES_MAX = 9, MIN_TENS_MAX = 5, HOUR_MAX = 23);
  - `TIME_RESET` = 16'h0000.
- Sub-module `bcd_hhmm_counter`:
  - inputs: `inc_min`, `inc_hr`, `carry_en`;
  - 16-bit BCD register;
  - `carry_en` = 1 lets minute wrap carry into hours;
  - instantiated twice: time with carry enabled for tick increments, alarm with carry disabled.
- Top level: prescaler, seconds counter, edge detectors, mode decode.

## Test plan
- `CLKS_PER_SEC` = 4, reset, RUN for 240 cycles → 60 ticks, `o_Seconds` back to 0, `o_Time` = 16'h0001.
- Preload 23:59 via SET_TIME (23 hour edges, 59 minute edges), return to RUN, run 60 ticks → `o_Time` = 16'h0000; while in SET_TIME, `o_Second_Tick` never asserts.
- SET_TIME: minute edge at 16'h0059 → 16'h0000 with hours unchanged; hour edge at 16'h2300 → 16'h0000.
- `i_Change_Time` = `i_Change_Alarm` = 1, one hour edge → `o_Time` hours +1, `o_Alarm_Time` unchanged; then SET_ALARM only, hour and minute edges in the same cycle → `o_Alarm_Time` = 16'h0101 one cycle later.
- RUN: toggle both increment inputs 5 times → no output change. Hold `i_Minutes_Inc` high across reset release → no increment.
- Assert `i_Rst_n` low mid-second with `o_Time` = 16'h1234 → all outputs zero immediately, before the next clock edge.
